// File: rtl/spi_flash_config_loader.sv
// spi_flash_config_loader
// Drives the eFPGA configuration write port from two sources: a bitstream
// streamed out of SPI NOR flash (READ 0x03, continuous read, SPI mode 0) and
// 32-bit host words from the USB configuration path. Host words always win
// and cut short any flash load in progress.
// Build option: define FLASH_HEADER_EN to treat the first flash word as a
// header (16'hFAB0 tag in [31:16], load length in [15:0]).
//
// state  | meaning
// IDLE   | cs_o high, waiting for start_i
// CMD    | shifting the 8-bit READ command 0x03
// ADDR   | shifting the 24-bit start address
// DATA   | receiving 32 bits of the current word on SCK rising edges
// STROBE | one cycle: emit (or, with a header, check) the assembled word
// FINISH | one cycle: cs_o high, done_o pulse, back to IDLE
module spi_flash_config_loader #(
  parameter logic [23:0] FLASH_START_ADDR = 24'h100000,
  parameter logic [15:0] WORD_COUNT       = 16'd1024,
  parameter int          SCK_DIV          = 2
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        start_i,
  input  logic [31:0] usb_write_data_i,
  input  logic        usb_write_strobe_i,
  output logic        sck_o,
  output logic        cs_o,
  output logic        pico_o,
  input  logic        poci_i,
  output logic [31:0] efpga_write_data_o,
  output logic        efpga_write_strobe_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        aborted_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    STROBE = 3'd4,
    FINISH = 3'd5
  } state_e;

  localparam int              DIV_W      = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(SCK_DIV - 1);
  localparam logic [7:0]      CMD_READ   = 8'h03;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        bit_q, bit_d;
  logic [31:0]       tx_q, tx_d;
  logic [31:0]       rx_q, rx_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              sck_q, sck_d;
  logic              cs_q, cs_d;
  logic              pico_q, pico_d;
  logic [31:0]       data_q, data_d;
  logic              strobe_q, strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic [15:0]       load_len;

`ifdef FLASH_HEADER_EN
  logic              hdr_q, hdr_d;
  logic [15:0]       len_q, len_d;
  assign load_len = len_q;
`else
  assign load_len = WORD_COUNT;
`endif

  // State, counters and every output are registered here.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      div_q      <= '0;
      bit_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      word_cnt_q <= '0;
      sck_q      <= 1'b0;
      cs_q       <= 1'b1;
      pico_q     <= 1'b0;
      data_q     <= '0;
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
`ifdef FLASH_HEADER_EN
      hdr_q      <= 1'b0;
      len_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      word_cnt_q <= word_cnt_d;
      sck_q      <= sck_d;
      cs_q       <= cs_d;
      pico_q     <= pico_d;
      data_q     <= data_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
`ifdef FLASH_HEADER_EN
      hdr_q      <= hdr_d;
      len_q      <= len_d;
`endif
    end
  end

  // Next-state logic: SPI sequencing, word emission, then host-word override.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bit_d      = bit_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    word_cnt_d = word_cnt_q;
    sck_d      = sck_q;
    cs_d       = cs_q;
    pico_d     = pico_q;
    data_d     = data_q;
    strobe_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
`ifdef FLASH_HEADER_EN
    hdr_d      = hdr_q;
    len_d      = len_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_i && !usb_write_strobe_i) begin
          state_d    = CMD;
          cs_d       = 1'b0;
          busy_d     = 1'b1;
          sck_d      = 1'b0;
          div_d      = DIV_RELOAD;
          bit_d      = 5'd7;
          tx_d       = {CMD_READ, FLASH_START_ADDR};
          pico_d     = CMD_READ[7];
          word_cnt_d = '0;
`ifdef FLASH_HEADER_EN
          hdr_d      = 1'b1;
`endif
        end
      end

      CMD, ADDR, DATA: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d = DIV_RELOAD;
          if (!sck_q) begin
            // Rising edge: the flash has held poci_i stable since the last fall.
            sck_d = 1'b1;
            if (state_q == DATA) begin
              rx_d = {rx_q[30:0], poci_i};
            end
          end else begin
            // Falling edge: advance pico_o so it settles a full half-period early.
            sck_d = 1'b0;
            if (bit_q != 5'd0) begin
              bit_d = bit_q - 5'd1;
              if (state_q != DATA) begin
                tx_d   = tx_q << 1;
                pico_d = tx_q[30];
              end
            end else if (state_q == CMD) begin
              state_d = ADDR;
              bit_d   = 5'd23;
              tx_d    = tx_q << 1;
              pico_d  = tx_q[30];
            end else if (state_q == ADDR) begin
              state_d = DATA;
              bit_d   = 5'd31;
              pico_d  = 1'b0;
            end else begin
              state_d = STROBE;
            end
          end
        end
      end

      STROBE: begin
        div_d = DIV_RELOAD;
        bit_d = 5'd31;
`ifdef FLASH_HEADER_EN
        if (hdr_q) begin
          hdr_d = 1'b0;
          if (rx_q[31:16] != 16'hFAB0 || rx_q[15:0] == 16'd0) begin
            state_d   = IDLE;
            cs_d      = 1'b1;
            sck_d     = 1'b0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
          end else begin
            len_d   = rx_q[15:0];
            state_d = DATA;
          end
        end else
`endif
        begin
          data_d     = rx_q;
          strobe_d   = 1'b1;
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_d == load_len) begin
            state_d = FINISH;
            cs_d    = 1'b1;
            sck_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end

      FINISH: begin
        state_d    = IDLE;
        word_cnt_d = '0;
        bit_d      = '0;
        div_d      = '0;
      end

      default: begin
        state_d = IDLE;
        cs_d    = 1'b1;
        sck_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A host word always goes out next cycle; during a load it also ends it,
    // discarding any partly assembled or just-completed flash word.
    if (usb_write_strobe_i) begin
      data_d   = usb_write_data_i;
      strobe_d = 1'b1;
      if (busy_q) begin
        state_d   = IDLE;
        cs_d      = 1'b1;
        sck_d     = 1'b0;
        pico_d    = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b1;
      end
    end
  end

  assign sck_o                = sck_q;
  assign cs_o                 = cs_q;
  assign pico_o               = pico_q;
  assign efpga_write_data_o   = data_q;
  assign efpga_write_strobe_o = strobe_q;
  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign aborted_o            = aborted_q;

endmodule

// File: tb/tb_spi_flash_config_loader.sv
// Bench for spi_flash_config_loader: a behavioural SPI NOR flash streams a
// random image; emitted words are compared against that image.
module tb_spi_flash_config_loader;

  localparam logic [23:0] ADDR = 24'h100000;
  localparam int          WC   = 4;
  localparam int          DIV  = 2;
`ifdef FLASH_HEADER_EN
  localparam int          HDR  = 1;
`else
  localparam int          HDR  = 0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] usb_write_data_i = '0;
  logic        usb_write_strobe_i = 1'b0;
  logic        poci_i = 1'b0;
  logic        sck_o, cs_o, pico_o;
  logic [31:0] efpga_write_data_o;
  logic        efpga_write_strobe_o, busy_o, done_o, aborted_o;

  spi_flash_config_loader #(
    .FLASH_START_ADDR(ADDR),
    .WORD_COUNT(16'(WC)),
    .SCK_DIV(DIV)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .start_i(start_i),
    .usb_write_data_i(usb_write_data_i),
    .usb_write_strobe_i(usb_write_strobe_i),
    .sck_o(sck_o),
    .cs_o(cs_o),
    .pico_o(pico_o),
    .poci_i(poci_i),
    .efpga_write_data_o(efpga_write_data_o),
    .efpga_write_strobe_o(efpga_write_strobe_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .aborted_o(aborted_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Flash image and observed output stream.
  logic [31:0] mem [0:15];
  logic [31:0] got_q [$];
  int          done_cnt = 0;
  int          abort_cnt = 0;

  // Flash model: receive 32 command/address bits on SCK rise, then stream the
  // image MSB first, changing poci on each SCK fall (mode 0, continuous read).
  int          rx_bits = 0;
  int          out_bit = 0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cur_word;
  logic        last_sck = 1'b0;

  always @(posedge sck_o or negedge sck_o or negedge cs_o) begin
    if (sck_o === last_sck) begin
      rx_bits  = 0;
      out_bit  = 0;
      cmd_addr = '0;
    end else if (cs_o === 1'b0) begin
      if (sck_o === 1'b1) begin
        if (rx_bits < 32) cmd_addr = {cmd_addr[30:0], pico_o};
        rx_bits++;
      end else if (rx_bits >= 32) begin
        cur_word = mem[(out_bit / 32) % 16];
        poci_i   = cur_word[31 - (out_bit % 32)];
        out_bit++;
      end
    end
    last_sck = sck_o;
  end

  always @(negedge clk_i) begin
    if (efpga_write_strobe_o === 1'b1) got_q.push_back(efpga_write_data_o);
    if (done_o === 1'b1) done_cnt++;
    if (aborted_o === 1'b1) abort_cnt++;
  end

  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_obs();
    got_q.delete();
    done_cnt = 0;
    abort_cnt = 0;
  endtask

  task automatic fill_image(input logic [31:0] hdr);
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    if (HDR == 1) mem[0] = hdr;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int n;
    n = 0;
    ok = 1'b0;
    while (n < limit && !ok) begin
      cyc();
      n++;
      if (done_o === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) cyc();
    total_cnt++;
    if ({sck_o, cs_o, pico_o, efpga_write_strobe_o, busy_o, done_o, aborted_o} !== 7'b0100000)
      $display("FAIL reset_ctrl got %b want 0100000",
               {sck_o, cs_o, pico_o, efpga_write_strobe_o, busy_o, done_o, aborted_o});
    else pass_cnt++;
    total_cnt++;
    if (efpga_write_data_o !== 32'h0)
      $display("FAIL reset_data got %h want 00000000", efpga_write_data_o);
    else pass_cnt++;
    reset_n_i = 1'b1;
    repeat (2) cyc();
  endtask

  task automatic check_load(input string name);
    total_cnt++;
    if (cmd_addr !== {8'h03, ADDR})
      $display("FAIL %s_cmd_addr got %h want %h", name, cmd_addr, {8'h03, ADDR});
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() !== WC)
      $display("FAIL %s_count got %0d want %0d", name, got_q.size(), WC);
    else pass_cnt++;
    for (int i = 0; i < WC && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== mem[HDR + i])
        $display("FAIL %s_word%0d got %h want %h", name, i, got_q[i], mem[HDR + i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_flash_load();
    int n;
    bit ok;
    fill_image({16'hFAB0, 16'(WC)});
    clear_obs();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    total_cnt++;
    if (cs_o !== 1'b0 || busy_o !== 1'b1)
      $display("FAIL load_start got cs=%b busy=%b want cs=0 busy=1", cs_o, busy_o);
    else pass_cnt++;
    n = 0;
    while (sck_o === 1'b0 && n < 100) begin
      n++;
      cyc();
    end
    total_cnt++;
    if (n !== DIV) $display("FAIL first_sck_delay got %0d want %0d", n, DIV);
    else pass_cnt++;
    wait_done(5000, ok);
    total_cnt++;
    if (!ok) $display("FAIL load_done timeout got 0 want 1");
    else pass_cnt++;
    total_cnt++;
    if (cs_o !== 1'b1 || busy_o !== 1'b0 || sck_o !== 1'b0)
      $display("FAIL load_end got cs=%b busy=%b sck=%b want 1 0 0", cs_o, busy_o, sck_o);
    else pass_cnt++;
    cyc();
    check_load("load");
    total_cnt++;
    if (done_cnt !== 1 || abort_cnt !== 0 || done_o !== 1'b0)
      $display("FAIL load_pulses got done=%0d abort=%0d done_now=%b want 1 0 0",
               done_cnt, abort_cnt, done_o);
    else pass_cnt++;
  endtask

  task automatic test_usb_idle();
    logic [31:0] w;
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 32'hA5A5_0001 : $urandom;
      usb_write_data_i = w;
      usb_write_strobe_i = 1'b1;
      start_i = (i == 3);
      cyc();
      usb_write_strobe_i = 1'b0;
      start_i = 1'b0;
      usb_write_data_i = ~w;
      total_cnt++;
      if (efpga_write_strobe_o !== 1'b1 || efpga_write_data_o !== w)
        $display("FAIL usb_idle%0d got strobe=%b data=%h want 1 %h",
                 i, efpga_write_strobe_o, efpga_write_data_o, w);
      else pass_cnt++;
      repeat (2) cyc();
      total_cnt++;
      if (efpga_write_strobe_o !== 1'b0 || efpga_write_data_o !== w ||
          cs_o !== 1'b1 || sck_o !== 1'b0 || busy_o !== 1'b0)
        $display("FAIL usb_idle_hold%0d got strobe=%b data=%h cs=%b sck=%b busy=%b want 0 %h 1 0 0",
                 i, efpga_write_strobe_o, efpga_write_data_o, cs_o, sck_o, busy_o, w);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    int n;
    fill_image({16'hFAB0, 16'(WC)});
    clear_obs();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    n = 0;
    while (got_q.size() == 0 && n < 3000) begin
      cyc();
      n++;
    end
    total_cnt++;
    if (got_q.size() == 0) $display("FAIL abort_first_word timeout got 0 want 1");
    else pass_cnt++;
    repeat ($urandom_range(5, 100)) cyc();
    usb_write_data_i = 32'h5555_AAAA;
    usb_write_strobe_i = 1'b1;
    cyc();
    usb_write_strobe_i = 1'b0;
    total_cnt++;
    if (aborted_o !== 1'b1 || cs_o !== 1'b1 || busy_o !== 1'b0 || sck_o !== 1'b0 ||
        efpga_write_strobe_o !== 1'b1 || efpga_write_data_o !== 32'h5555_AAAA)
      $display("FAIL abort_cycle got ab=%b cs=%b busy=%b sck=%b stb=%b data=%h want 1 1 0 0 1 5555aaaa",
               aborted_o, cs_o, busy_o, sck_o, efpga_write_strobe_o, efpga_write_data_o);
    else pass_cnt++;
    repeat (700) cyc();
    total_cnt++;
    if (got_q.size() !== 2 || done_cnt !== 0 || abort_cnt !== 1)
      $display("FAIL abort_after got words=%0d done=%0d abort=%0d want 2 0 1",
               got_q.size(), done_cnt, abort_cnt);
    else pass_cnt++;
    if (got_q.size() == 2) begin
      total_cnt++;
      if (got_q[0] !== mem[HDR] || got_q[1] !== 32'h5555_AAAA)
        $display("FAIL abort_words got %h %h want %h 5555aaaa", got_q[0], got_q[1], mem[HDR]);
      else pass_cnt++;
    end
  endtask

  task automatic test_start_ignored();
    bit ok;
    fill_image({16'hFAB0, 16'(WC)});
    clear_obs();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(20, 150)) cyc();
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
    end
    wait_done(5000, ok);
    total_cnt++;
    if (!ok) $display("FAIL restart_done timeout got 0 want 1");
    else pass_cnt++;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    repeat (3) cyc();
    total_cnt++;
    if (busy_o !== 1'b0 || cs_o !== 1'b1)
      $display("FAIL start_in_finish got busy=%b cs=%b want 0 1", busy_o, cs_o);
    else pass_cnt++;
    check_load("restart");
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL restart_done_count got %0d want 1", done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    fill_image({16'hFAB0, 16'(WC)});
    clear_obs();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    n = 0;
    while (rx_bits < 14 && n < 500) begin
      cyc();
      n++;
    end
    #2;
    reset_n_i = 1'b0;
    #1;
    total_cnt++;
    if (cs_o !== 1'b1 || sck_o !== 1'b0 || busy_o !== 1'b0 || pico_o !== 1'b0)
      $display("FAIL reset_mid got cs=%b sck=%b busy=%b pico=%b want 1 0 0 0",
               cs_o, sck_o, busy_o, pico_o);
    else pass_cnt++;
    repeat (3) cyc();
    reset_n_i = 1'b1;
    repeat (2) cyc();
    fill_image({16'hFAB0, 16'(WC)});
    clear_obs();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_done(5000, ok);
    total_cnt++;
    if (!ok) $display("FAIL reload_done timeout got 0 want 1");
    else pass_cnt++;
    cyc();
    check_load("reload");
  endtask

  task automatic test_usb_in_strobe();
    int k;
    bit ok;
    logic [31:0] w;
    fill_image({16'hFAB0, 16'(WC)});
    clear_obs();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    k = 1;
    while (efpga_write_strobe_o !== 1'b1 && k < 3000) begin
      cyc();
      k++;
    end
    wait_done(5000, ok);
    repeat (3) cyc();
    fill_image({16'hFAB0, 16'(WC)});
    clear_obs();
    w = $urandom;
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    repeat (k - 2) cyc();
    usb_write_data_i = w;
    usb_write_strobe_i = 1'b1;
    cyc();
    usb_write_strobe_i = 1'b0;
    total_cnt++;
    if (aborted_o !== 1'b1 || efpga_write_strobe_o !== 1'b1 || efpga_write_data_o !== w || cs_o !== 1'b1)
      $display("FAIL usb_at_strobe got ab=%b stb=%b data=%h cs=%b want 1 1 %h 1",
               aborted_o, efpga_write_strobe_o, efpga_write_data_o, cs_o, w);
    else pass_cnt++;
    repeat (400) cyc();
    total_cnt++;
    if (got_q.size() !== 1 || done_cnt !== 0 || abort_cnt !== 1)
      $display("FAIL usb_at_strobe_after got words=%0d done=%0d abort=%0d want 1 0 1",
               got_q.size(), done_cnt, abort_cnt);
    else pass_cnt++;
  endtask

`ifdef FLASH_HEADER_EN
  task automatic test_header();
    int n;
    bit ok;
    fill_image(32'hFAB0_0003);
    clear_obs();
    start_i = 1'b1;
    cyc();
    start_i = 1'b0;
    wait_done(5000, ok);
    cyc();
    total_cnt++;
    if (!ok || got_q.size() !== 3)
      $display("FAIL header_len got done=%b words=%0d want 1 3", ok, got_q.size());
    else pass_cnt++;
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      total_cnt++;
      if (got_q[i] !== mem[1 + i])
        $display("FAIL header_word%0d got %h want %h", i, got_q[i], mem[1 + i]);
      else pass_cnt++;
    end
    for (int t = 0; t < 2; t++) begin
      fill_image((t == 0) ? 32'h1234_0003 : 32'hFAB0_0000);
      clear_obs();
      start_i = 1'b1;
      cyc();
      start_i = 1'b0;
      n = 0;
      while (aborted_o !== 1'b1 && n < 3000) begin
        cyc();
        n++;
      end
      total_cnt++;
      if (aborted_o !== 1'b1 || cs_o !== 1'b1 || busy_o !== 1'b0)
        $display("FAIL header_bad%0d got ab=%b cs=%b busy=%b want 1 1 0", t, aborted_o, cs_o, busy_o);
      else pass_cnt++;
      repeat (300) cyc();
      total_cnt++;
      if (got_q.size() !== 0 || done_cnt !== 0)
        $display("FAIL header_bad_words%0d got %0d done=%0d want 0 0", t, got_q.size(), done_cnt);
      else pass_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_flash_load();
    test_usb_idle();
    test_abort();
    test_start_ignored();
    test_reset_mid();
    test_usb_in_strobe();
`ifdef FLASH_HEADER_EN
    test_header();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_flash_config_loader.md
Name: spi_flash_config_loader

Overview:
- Sequences the eFPGA configuration write port from two sources.
- Autonomous source: a bitstream read from SPI NOR flash using the READ command 0x03.
- Host source: pass-through of 32-bit words from the USB configuration path.
- USB words always take priority and abort any flash load in progress.
- Sits between the USB config logic and the efpga_write_data/strobe outputs of the top-level controller, and drives the SPI flash pins.

Parameters:
- FLASH_START_ADDR, 24'h100000, byte address of the first bitstream word in flash.
- WORD_COUNT, 16'd1024, number of 32-bit words loaded (1..65535).
- SCK_DIV, 2, clk_i cycles per SCK half-period (>=1).

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle pulse; begins a flash load when idle.
- usb_write_data_i  in  32  word from the USB config path.
- usb_write_strobe_i  in  1  single-cycle valid for usb_write_data_i.
- sck_o  out  1  SPI clock, mode 0.
- cs_o  out  1  flash chip select, active low.
- pico_o  out  1  SPI data to flash.
- poci_i  in  1  SPI data from flash.
- efpga_write_data_o  out  32  configuration word.
- efpga_write_strobe_o  out  1  one-cycle word-valid strobe.
- busy_o  out  1  flash load in progress.
- done_o  out  1  one-cycle pulse when a flash load completes normally.
- aborted_o  out  1  one-cycle pulse when a flash load is cut short by USB.

Behaviour:
- Clock/reset: one clock (clk_i); reset_n_i is asynchronous, active-low.
- Reset values:
  - sck_o=0, cs_o=1, pico_o=0.
  - efpga_write_data_o=0, efpga_write_strobe_o=0.
  - busy_o=0, done_o=0, aborted_o=0.
  - FSM in IDLE; all counters 0.
- All outputs are registered.
- FSM states: IDLE, CMD, ADDR, DATA, STROBE, FINISH.
  - IDLE: on start_i -> CMD, cs_o=0, busy_o=1 from the next cycle.
  - CMD: shifts 8'h03, MSB first.
  - ADDR: shifts FLASH_START_ADDR, 24 bits, MSB first.
  - DATA: 32 SCK cycles. poci_i is sampled on each SCK rising edge into the word register, MSB first, so the first byte read lands in bits [31:24].
  - STROBE: one cycle.
    - efpga_write_data_o = assembled word, efpga_write_strobe_o=1.
    - Word counter increments.
    - If counter == WORD_COUNT -> FINISH, else -> DATA.
    - cs_o stays low across words, which relies on flash continuous read.
  - FINISH: cs_o=1, sck_o=0, busy_o=0, done_o pulse -> IDLE. Total one cycle.
- SPI timing:
  - sck_o toggles every SCK_DIV clocks while in CMD/ADDR/DATA.
  - pico_o updates only while sck_o is low, at least SCK_DIV clocks before the rising edge.
  - sck_o idles low and is low in STROBE.
  - First SCK rising edge occurs SCK_DIV clocks after cs_o falls.
- Bit counter: 5 bits, reloaded per phase (7, 23, 31).
- USB pass-through:
  - usb_write_strobe_i=1 -> next cycle efpga_write_data_o=usb_write_data_i, efpga_write_strobe_o=1. Latency is 1 cycle in any state.
  - efpga_write_data_o holds its last value when no strobe is issued.
- USB abort:
  - A usb_write_strobe_i while busy_o=1 forces: cs_o=1, sck_o=0, busy_o=0, aborted_o pulse, FSM -> IDLE, all on the next cycle.
  - The partial flash word is discarded.
- Simultaneous events:
  - USB strobe in the same cycle as STROBE: USB word is forwarded, flash word dropped, abort taken.
  - start_i while busy_o=1: ignored.
  - start_i together with usb_write_strobe_i in IDLE: USB forwarded, start ignored.
  - start_i in the FINISH cycle: ignored.
- Reset mid-load: immediate return to reset values. cs_o rises asynchronously.

Optional Feature:
- Macro: FLASH_HEADER_EN.
- Defined:
  - The first 32-bit word read after ADDR is a header and is not strobed out.
  - header[15:0] replaces WORD_COUNT as the load length.
  - header[31:16] must equal 16'hFAB0. On mismatch, or when the length is 0: cs_o=1, aborted_o pulse, no words emitted.
- Undefined: WORD_COUNT is used; no header is read.

Test Plan:
- SCK_DIV=1, WORD_COUNT=2, flash model returns 32'hDEADBEEF, 32'h01234567 -> pico shows 0x03 then 0x100000. Exactly two strobes with those values, then done_o pulse, cs_o=1, busy_o=0.
- Idle, usb_write_strobe_i with data 32'hA5A5_0001 -> one cycle later strobe=1, data=32'hA5A5_0001; no SPI activity.
- During word 1 of a 4-word load, USB strobe with 32'h5555_AAAA -> next cycle aborted_o=1, cs_o=1, USB word emitted; no further flash strobes.
- start_i pulsed again mid-load -> ignored: the original load completes with exactly WORD_COUNT strobes and one done_o.
- reset_n_i low during ADDR -> cs_o=1 and sck_o=0 immediately. After release, start_i gives a clean load from the command byte.
- FLASH_HEADER_EN: header 32'hFAB0_0003 -> 3 words strobed. Header 32'h1234_0003 -> aborted_o, 0 strobes.
